// File: rtl/stream_unpack_6to3.sv
`default_nettype none
// ============================================================================
// Module  : stream_unpack_6to3
// Purpose : Splits 48-bit two-pixel words into 24-bit pixels tagged with
//           start-of-frame / end-of-line / end-of-frame raster flags.
// Revision: 1.0 - initial release
// ============================================================================
module stream_unpack_6to3 #(
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224,
  parameter int CNT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] stream_in,
  input  logic        stream_in_valid,
  output logic        stream_in_ready,
  output logic [23:0] stream_out,
  output logic        stream_out_valid,
  input  logic        stream_out_ready,
  output logic        stream_out_sof,
  output logic        stream_out_eol,
  output logic        stream_out_eof
);

  localparam logic [CNT_WIDTH-1:0] c_col_last = CNT_WIDTH'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] c_row_last = CNT_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

  logic [47:0]          r_buf;
  logic                 r_full;
  logic                 r_phase;
  logic [CNT_WIDTH-1:0] r_col;
  logic [CNT_WIDTH-1:0] r_row;

  logic w_in_fire;
  logic w_out_fire;
  logic w_col_wrap;
  logic w_row_wrap;

  // Refill is allowed in the same cycle the high half leaves, so a word
  // arrives every second beat without a bubble.
  assign stream_in_ready = !r_full || (r_phase && stream_out_ready);
  assign w_in_fire       = stream_in_valid && stream_in_ready;
  assign w_out_fire      = r_full && stream_out_ready;
  assign w_col_wrap      = (r_col == c_col_last);
  assign w_row_wrap      = (r_row == c_row_last);

  assign stream_out       = r_phase ? r_buf[47:24] : r_buf[23:0];
  assign stream_out_valid = r_full;
  assign stream_out_sof   = r_full && (r_col == '0) && (r_row == '0);
  assign stream_out_eol   = r_full && w_col_wrap;
  assign stream_out_eof   = r_full && w_col_wrap && w_row_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf   <= '0;
      r_full  <= 1'b0;
      r_phase <= 1'b0;
    end else if (w_in_fire) begin
      r_buf   <= stream_in;
      r_full  <= 1'b1;
      r_phase <= 1'b0;
    end else if (w_out_fire) begin
      if (!r_phase) begin
        r_phase <= 1'b1;
      end else begin
        r_full  <= 1'b0;
        r_phase <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_out_fire) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_wrap ? '0 : r_row + c_cnt_one;
      end else begin
        r_col <= r_col + c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire
